load_store_unit: RTL and testbench

Single-outstanding data-memory access unit sitting directly downstream of the core's execute stage. It takes the effective address (ALU result), store data (rs2), destination register and access type. It then runs one bus transaction with a valid/ready request channel and an rvalid response channel. Finally it returns the aligned, sign- or zero-extended load result or a store completion to the writeback stage. Misaligned or illegal accesses complete with a fault flag and no bus activity.

---
 rtl/load_store_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Single-outstanding data-memory access unit between execute and writeback.
// Accepts one access at a time and checks its alignment and size. For a
// legal access it runs one valid/ready bus request, plus an rvalid response
// for loads. It then returns one completion pulse carrying the aligned,
// extended load data or a store/fault completion.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   req_valid_i          execute stage presents an access
//   req_ready_o          unit idle (combinational from state)
//   req_op_i[3:0]        {store, unsigned, size[1:0]}; size 11 is illegal
//   req_addr_i           byte address
//   req_wdata_i          store data, right-justified
//   req_rd_i             destination register tag
//   rsp_valid_o          one-cycle completion pulse
//   rsp_we_o             register write required (load without fault)
//   rsp_rd_o             tag of completed access
//   rsp_data_o           extended load data; 0 for stores and faults
//   rsp_fault_o          misaligned access or illegal size
//   bus_valid_o          bus request pending
//   bus_ready_i          bus accepts request
//   bus_we_o             write request
//   bus_addr_o           word-aligned address
//   bus_wstrb_o          byte enables; 0 for reads
//   bus_wdata_o          lane-replicated store data
//   bus_rvalid_i         read data valid
//   bus_rdata_i          read word
module load_store_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  output logic        rsp_we_o,
  output logic [4:0]  rsp_rd_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_fault_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_we_q, rsp_we_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_fault_q, rsp_fault_d;

  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return |a;
      default: return 1'b1;
    endcase
  endfunction

  // Replicate the store operand across all lanes so the strobe alone picks
  // the destination bytes.
  function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] fmt_wstrb(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] a, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    b  = d[{a, 3'b000} +: 8];
    h  = d[{a[1], 4'b0000} +: 16];
    bs = b;
    hs = h;
    case (size)
      2'b00:   return uns ? {24'b0, b} : bs;
      2'b01:   return uns ? {16'b0, h} : hs;
      default: return d;
    endcase
  endfunction

  assign req_ready_o = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d   = req_op_i;
          lane_d = req_addr_i[1:0];
          rd_d   = req_rd_i;
          if (is_fault(req_op_i[1:0], req_addr_i[1:0])) begin
            // Faults skip the bus entirely and complete on the next cycle.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_data_d  = 32'h0;
            rsp_rd_d    = req_rd_i;
          end else begin
            state_d     = REQ;
            bus_valid_d = 1'b1;
            bus_we_d    = req_op_i[3];
            bus_addr_d  = {req_addr_i[31:2], 2'b00};
            bus_wstrb_d = req_op_i[3] ? fmt_wstrb(req_op_i[1:0], req_addr_i[1:0]) : 4'b0000;
            bus_wdata_d = req_op_i[3] ? fmt_wdata(req_op_i[1:0], req_wdata_i) : 32'h0;
          end
        end
      end
      REQ: begin
        if (bus_ready_i) begin
          bus_valid_d = 1'b0;
          if (op_q[3]) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'h0;
            rsp_rd_d    = rd_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b1;
          rsp_data_d  = extract_load(op_q[1:0], op_q[2], lane_q, bus_rdata_i);
          rsp_rd_d    = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      op_q        <= 4'h0;
      lane_q      <= 2'b00;
      rd_q        <= 5'h0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wstrb_q <= 4'h0;
      bus_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rd_q    <= 5'h0;
      rsp_data_q  <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus_valid_o = bus_valid_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wstrb_o = bus_wstrb_q;
  assign bus_wdata_o = bus_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_fault_o = rsp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_we;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  load_store_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_rd_i     (req_rd),
    .rsp_valid_o  (rsp_valid),
    .rsp_we_o     (rsp_we),
    .rsp_rd_o     (rsp_rd),
    .rsp_data_o   (rsp_data),
    .rsp_fault_o  (rsp_fault),
    .bus_valid_o  (bus_valid),
    .bus_ready_i  (bus_ready),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_wstrb_o  (bus_wstrb),
    .bus_wdata_o  (bus_wdata),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_we, rsp_fault, bus_valid, bus_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {rsp_valid, rsp_we, rsp_fault, bus_valid, bus_we});
    end
    checks++;
    if ({bus_wstrb, bus_addr, bus_wdata, rsp_data, rsp_rd} !== 105'b0) begin
      failures++;
      $display("FAIL reset_data wstrb=%h addr=%h wdata=%h data=%h rd=%0d want all 0",
               bus_wstrb, bus_addr, bus_wdata, rsp_data, rsp_rd);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_store_byte();
    bus_ready = 1'b1;
    present(4'b1000, 32'h0000_1003, 32'h0000_00AB, 5'd3);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({bus_valid, bus_we, req_ready, rsp_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL sb_req_ctrl got=%b want=1100", {bus_valid, bus_we, req_ready, rsp_valid});
    end
    checks++;
    if (bus_addr !== 32'h0000_1000 || bus_wstrb !== 4'b1000 || bus_wdata !== 32'hABAB_ABAB) begin
      failures++;
      $display("FAIL sb_bus addr=%h wstrb=%b wdata=%h want 00001000 1000 abababab",
               bus_addr, bus_wstrb, bus_wdata);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_we, rsp_fault, bus_valid} !== 4'b1000 || rsp_data !== 32'h0 || rsp_rd !== 5'd3) begin
      failures++;
      $display("FAIL sb_rsp v/we/f/bv=%b data=%h rd=%0d want 1000 0 3",
               {rsp_valid, rsp_we, rsp_fault, bus_valid}, rsp_data, rsp_rd);
    end
    bus_ready = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL sb_done rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_load_half_signed();
    bus_ready = 1'b0;
    present(4'b0001, 32'h0000_2002, 32'h0, 5'd7);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_valid !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h0000_2000 || bus_wstrb !== 4'b0) begin
        failures++;
        $display("FAIL lh_hold%0d valid=%b we=%b addr=%h wstrb=%b want 1 0 00002000 0000",
                 i, bus_valid, bus_we, bus_addr, bus_wstrb);
      end
      tick();
    end
    bus_ready = 1'b1;
    checks++;
    if (bus_valid !== 1'b1 || bus_addr !== 32'h0000_2000) begin
      failures++;
      $display("FAIL lh_hs valid=%b addr=%h want 1 00002000", bus_valid, bus_addr);
    end
    tick();
    bus_ready = 1'b0;
    checks++;
    if (bus_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lh_wait bus_valid=%b rsp_valid=%b want 0 0", bus_valid, rsp_valid);
    end
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h8001_1234;
    tick();
    bus_rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_fault !== 1'b0 ||
        rsp_data !== 32'hFFFF_8001 || rsp_rd !== 5'd7) begin
      failures++;
      $display("FAIL lh_rsp v=%b we=%b f=%b data=%h rd=%0d want 1 1 0 ffff8001 7",
               rsp_valid, rsp_we, rsp_fault, rsp_data, rsp_rd);
    end
    tick();
  endtask

  task automatic test_load_byte();
    logic [31:0] exp [2];
    exp[0] = 32'h0000_00F0;
    exp[1] = 32'hFFFF_FFF0;
    for (int i = 0; i < 2; i++) begin
      present((i == 0) ? 4'b0100 : 4'b0000, 32'h0000_0001, 32'h0, 5'd10 + 5'(i));
      tick();
      req_valid = 1'b0;
      bus_ready = 1'b1;
      tick();
      bus_ready  = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h0000_F000;
      tick();
      bus_rvalid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_rd !== 5'd10 + 5'(i)) begin
        failures++;
        $display("FAIL lb%0d v=%b data=%h rd=%0d want 1 %h %0d",
                 i, rsp_valid, rsp_data, rsp_rd, exp[i], 10 + i);
      end
      tick();
    end
  endtask

  task automatic test_fault();
    logic [3:0]  ops [2];
    logic [31:0] adr [2];
    ops[0] = 4'b0010; adr[0] = 32'h0000_0006;
    ops[1] = 4'b0011; adr[1] = 32'h0000_0000;
    for (int i = 0; i < 2; i++) begin
      present(ops[i], adr[i], 32'h5555_5555, 5'd20 + 5'(i));
      tick();
      req_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_fault, rsp_we, bus_valid} !== 4'b1100 || rsp_data !== 32'h0 ||
          rsp_rd !== 5'd20 + 5'(i)) begin
        failures++;
        $display("FAIL fault%0d v/f/we/bv=%b data=%h rd=%0d want 1100 0 %0d",
                 i, {rsp_valid, rsp_fault, rsp_we, bus_valid}, rsp_data, rsp_rd, 20 + i);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL fault%0d_after v=%b bv=%b rdy=%b want 0 0 1", i, rsp_valid, bus_valid, req_ready);
      end
    end
  endtask

  task automatic test_spurious();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEAD_BEEF;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL spur_idle rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
    present(4'b0010, 32'h0000_0010, 32'h0, 5'd5);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || bus_valid !== 1'b1) begin
      failures++;
      $display("FAIL spur_req rsp_valid=%b bus_valid=%b want 0 1", rsp_valid, bus_valid);
    end
    bus_rvalid = 1'b0;
    bus_ready  = 1'b1;
    tick();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    tick();
    bus_rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678 || rsp_rd !== 5'd5) begin
      failures++;
      $display("FAIL spur_rsp v=%b data=%h rd=%0d want 1 12345678 5", rsp_valid, rsp_data, rsp_rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus_ready = 1'b1;
    present(4'b0010, 32'h0000_0100, 32'h0, 5'd1);
    tick();
    // Request held high while busy must be ignored.
    present(4'b0010, 32'h0000_0104, 32'h0, 5'd2);
    checks++;
    if (req_ready !== 1'b0 || bus_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL b2b_req1 rdy=%b addr=%h want 0 00000100", req_ready, bus_addr);
    end
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hAAAA_0001;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_wait1 rdy=%b want 0", req_ready);
    end
    tick();
    bus_rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rd !== 5'd1 || rsp_data !== 32'hAAAA_0001 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rsp1 v=%b rd=%0d data=%h rdy=%b want 1 1 aaaa0001 0",
               rsp_valid, rsp_rd, rsp_data, req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle rdy=%b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || bus_addr !== 32'h0000_0104) begin
      failures++;
      $display("FAIL b2b_req2 rdy=%b addr=%h want 0 00000104", req_ready, bus_addr);
    end
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBBBB_0002;
    tick();
    bus_rvalid = 1'b0;
    bus_ready  = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rd !== 5'd2 || rsp_data !== 32'hBBBB_0002) begin
      failures++;
      $display("FAIL b2b_rsp2 v=%b rd=%0d data=%h want 1 2 bbbb0002", rsp_valid, rsp_rd, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus_ready = 1'b1;
    present(4'b0010, 32'h0000_0020, 32'h0, 5'd9);
    tick();
    req_valid = 1'b0;
    tick();
    bus_ready = 1'b0;
    resetn = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_we, rsp_fault, bus_valid, bus_we} !== 5'b0 || req_ready !== 1'b1 ||
        {bus_wstrb, bus_addr, bus_wdata, rsp_data, rsp_rd} !== 105'b0) begin
      failures++;
      $display("FAIL rmid_outs ctrl=%b rdy=%b addr=%h data=%h rd=%0d want 00000 1 0 0 0",
               {rsp_valid, rsp_we, rsp_fault, bus_valid, bus_we}, req_ready, bus_addr, rsp_data, rsp_rd);
    end
    resetn     = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    tick();
    tick();
    bus_rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_late v=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
    bus_ready = 1'b1;
    present(4'b1010, 32'h0000_0040, 32'h1122_3344, 5'd12);
    tick();
    req_valid = 1'b0;
    checks++;
    if (bus_valid !== 1'b1 || bus_wstrb !== 4'b1111 || bus_wdata !== 32'h1122_3344 ||
        bus_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL rmid_sw v=%b wstrb=%b wdata=%h addr=%h want 1 1111 11223344 00000040",
               bus_valid, bus_wstrb, bus_wdata, bus_addr);
    end
    tick();
    bus_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rd !== 5'd12) begin
      failures++;
      $display("FAIL rmid_rsp v=%b we=%b rd=%0d want 1 0 12", rsp_valid, rsp_we, rsp_rd);
    end
    tick();
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_op     = 4'h0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'h0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    test_reset();
    test_store_byte();
    test_load_half_signed();
    test_load_byte();
    test_fault();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
